// File: rtl/conv_pkg.sv
// Shared definitions for the CONV host/memory block.
// Holds the default data/address widths, the csel bank codes with their
// validity check, and the host run-handshake state encoding.
package conv_pkg;

    localparam int DATA_WIDTH = 20;
    localparam int IMG_AW     = 12;
    localparam int L1_AW      = 10;
    localparam int L2_AW      = 11;

    localparam logic [2:0] CSEL_L0K0 = 3'd1;
    localparam logic [2:0] CSEL_L0K1 = 3'd2;
    localparam logic [2:0] CSEL_L1K0 = 3'd3;
    localparam logic [2:0] CSEL_L1K1 = 3'd4;
    localparam logic [2:0] CSEL_L2   = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } host_state_e;

    // Codes 1..5 name a result bank; 0, 6 and 7 are unused encodings.
    function automatic logic csel_valid(input logic [2:0] sel);
        return (sel >= CSEL_L0K0) && (sel <= CSEL_L2);
    endfunction

endpackage

// File: rtl/conv_bank_ram.sv
// Simple synchronous RAM: one write port and NRD strobed, registered read
// ports. A read to the address being written in the same cycle returns the
// old word.
// Ports:
//   clk, reset  - clock; synchronous active-high reset clears the read registers only
//   we/waddr/wdata - write port
//   re/raddr/rdata - NRD read ports; rdata[p] updates only when re[p]=1
module conv_bank_ram #(
    parameter int AW  = 10,
    parameter int DW  = 20,
    parameter int NRD = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [NRD-1:0]           re,
    input  logic [NRD-1:0][AW-1:0]   raddr,
    output logic [NRD-1:0][DW-1:0]   rdata
);

    logic [DW-1:0] mem_q [2**AW];

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [DW-1:0] rdata_q;

        // Registered read; non-blocking array update makes same-cycle reads see old data.
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q <= '0;
            end else if (re[p]) begin
                rdata_q <= mem_q[raddr[p]];
            end
        end

        assign rdata[p] = rdata_q;
    end

endmodule

// File: rtl/conv_host_mem.sv
// Host/memory end of the CONV accelerator interface.
// Owns the image RAM, the five csel-addressed result banks and the
// ready/busy run handshake with its timeout.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   ready/busy/start/done      - run handshake (ready to CONV, busy from CONV)
//   iaddr/idata                - image read, 1-cycle latency
//   cwr/caddr_wr/cdata_wr      - result write into bank csel
//   crd/caddr_rd/cdata_rd      - result read-back from bank csel, 1-cycle latency
//   img_we/img_addr/img_wdata  - host image load (IDLE only)
//   dump_sel/dump_addr/dump_data - host bank dump, 1-cycle latency
//   err                        - sticky protocol/timeout error
module conv_host_mem #(
    parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int IMG_AW     = conv_pkg::IMG_AW,
    parameter int L1_AW      = conv_pkg::L1_AW,
    parameter int L2_AW      = conv_pkg::L2_AW,
    parameter int TIMEOUT    = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  busy,
    input  logic [IMG_AW-1:0]     iaddr,
    output logic [DATA_WIDTH-1:0] idata,
    input  logic                  cwr,
    input  logic [IMG_AW-1:0]     caddr_wr,
    input  logic [DATA_WIDTH-1:0] cdata_wr,
    input  logic                  crd,
    input  logic [IMG_AW-1:0]     caddr_rd,
    output logic [DATA_WIDTH-1:0] cdata_rd,
    input  logic [2:0]            csel,
    input  logic                  start,
    input  logic                  img_we,
    input  logic [IMG_AW-1:0]     img_addr,
    input  logic [DATA_WIDTH-1:0] img_wdata,
    input  logic [2:0]            dump_sel,
    input  logic [IMG_AW-1:0]     dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  done,
    output logic                  err
);
    import conv_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    host_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [2:0]    rd_sel_q, rd_sel_d;
    logic [2:0]    dump_sel_q;
    logic          timeout_s;
    logic          wr_ok_s, rd_ok_s, img_we_ok_s, acc_err_s;
    logic [4:0]    bank_we_s, bank_re_s;
    logic [1:0][DATA_WIDTH-1:0] bank_rdata_s [5];

    // L1/L2 banks are shallower than the shared address bus; any bit above their depth is out of range.
    function automatic logic addr_fits(input logic [2:0] sel, input logic [IMG_AW-1:0] addr);
        case (sel)
            CSEL_L1K0, CSEL_L1K1: return (addr >> L1_AW) == '0;
            CSEL_L2:              return (addr >> L2_AW) == '0;
            default:              return 1'b1;
        endcase
    endfunction

    // Access qualification and bank strobe decode.
    always_comb begin
        wr_ok_s     = cwr && csel_valid(csel) && addr_fits(csel, caddr_wr);
        rd_ok_s     = crd && csel_valid(csel) && addr_fits(csel, caddr_rd);
        img_we_ok_s = img_we && (state_q == IDLE);
        acc_err_s   = (cwr && !wr_ok_s) || (crd && !rd_ok_s) || (img_we && !img_we_ok_s);
        for (int i = 0; i < 5; i++) begin
            bank_we_s[i] = wr_ok_s && (csel == 3'(i + 1));
            bank_re_s[i] = rd_ok_s && (csel == 3'(i + 1));
        end
    end

    conv_bank_ram #(.AW(IMG_AW), .DW(DATA_WIDTH), .NRD(1)) u_img (
        .clk   (clk),
        .reset (reset),
        .we    (img_we_ok_s),
        .waddr (img_addr),
        .wdata (img_wdata),
        .re    (1'b1),
        .raddr (iaddr),
        .rdata (idata)
    );

    // Banks 0..4 correspond to csel 1..5; port 1 serves crd, port 0 serves the host dump.
    for (genvar b = 0; b < 5; b++) begin : g_bank
        localparam int BAW = (b < 2) ? IMG_AW : ((b < 4) ? L1_AW : L2_AW);
        conv_bank_ram #(.AW(BAW), .DW(DATA_WIDTH), .NRD(2)) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (bank_we_s[b]),
            .waddr (caddr_wr[BAW-1:0]),
            .wdata (cdata_wr),
            .re    ({bank_re_s[b], 1'b1}),
            .raddr ({caddr_rd[BAW-1:0], dump_addr[BAW-1:0]}),
            .rdata (bank_rdata_s[b])
        );
    end

    // Run handshake next-state logic with ARM/RUN timeout.
    always_comb begin
        state_d   = state_q;
        timeout_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = ARM;
                else       state_d = IDLE;
            end
            ARM: begin
                if ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT)) begin
                    state_d   = IDLE;
                    timeout_s = 1'b1;
                end else if (busy) begin
                    state_d = RUN;
                end else begin
                    state_d = ARM;
                end
            end
            RUN: begin
                if ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT)) begin
                    state_d   = IDLE;
                    timeout_s = 1'b1;
                end else if (!busy) begin
                    state_d = FIN;
                end else begin
                    state_d = RUN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Counter restarts on every state change so it measures time spent in the current state.
        if (state_d != state_q) cnt_d = '0;
        else                    cnt_d = cnt_q + 1'b1;
        err_d = err_q | timeout_s | acc_err_s;
        if (rd_ok_s) rd_sel_d = csel;
        else         rd_sel_d = rd_sel_q;
    end

    // State, counter, error and read-source registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rd_sel_q   <= 3'd0;
            dump_sel_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rd_sel_q   <= rd_sel_d;
            dump_sel_q <= dump_sel;
        end
    end

    // Output steering from the registered bank read data.
    always_comb begin
        case (rd_sel_q)
            CSEL_L0K0: cdata_rd = bank_rdata_s[0][1];
            CSEL_L0K1: cdata_rd = bank_rdata_s[1][1];
            CSEL_L1K0: cdata_rd = bank_rdata_s[2][1];
            CSEL_L1K1: cdata_rd = bank_rdata_s[3][1];
            CSEL_L2:   cdata_rd = bank_rdata_s[4][1];
            default:   cdata_rd = '0;
        endcase
        case (dump_sel_q)
            CSEL_L0K0: dump_data = bank_rdata_s[0][0];
            CSEL_L0K1: dump_data = bank_rdata_s[1][0];
            CSEL_L1K0: dump_data = bank_rdata_s[2][0];
            CSEL_L1K1: dump_data = bank_rdata_s[3][0];
            CSEL_L2:   dump_data = bank_rdata_s[4][0];
            default:   dump_data = '0;
        endcase
    end

    assign ready = (state_q == ARM);
    assign done  = (state_q == FIN);
    assign err   = err_q;

endmodule

// File: tb/tb_conv_host_mem.sv
// Directed self-checking bench for conv_host_mem (TIMEOUT shortened to 16).
module tb_conv_host_mem;

    logic        clk = 1'b0;
    logic        reset, busy, cwr, crd, start, img_we;
    logic [11:0] iaddr, caddr_wr, caddr_rd, img_addr, dump_addr;
    logic [19:0] cdata_wr, img_wdata;
    logic [2:0]  csel, dump_sel;
    logic        ready, done, err;
    logic [19:0] idata, cdata_rd, dump_data;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        saw_done;

    conv_host_mem #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .start(start),
        .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
        .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; busy = 1'b0; cwr = 1'b0; crd = 1'b0; start = 1'b0; img_we = 1'b0;
        iaddr = 12'h000; caddr_wr = 12'h000; caddr_rd = 12'h000; img_addr = 12'h000;
        dump_addr = 12'h000; cdata_wr = 20'h00000; img_wdata = 20'h00000;
        csel = 3'd0; dump_sel = 3'd0;
        step(); step();
        reset = 1'b0;
        chk("rst_ready", {19'd0, ready}, 20'd0);
        chk("rst_done", {19'd0, done}, 20'd0);
        chk("rst_err", {19'd0, err}, 20'd0);
        chk("rst_idata", idata, 20'h00000);
        chk("rst_cdata_rd", cdata_rd, 20'h00000);
        chk("rst_dump", dump_data, 20'h00000);

        // Image load and read
        img_we = 1'b1; img_addr = 12'h041; img_wdata = 20'h0A5A5; step();
        img_addr = 12'h042; img_wdata = 20'h12345; step();
        img_we = 1'b0; iaddr = 12'h041; step();
        chk("img_rd_41", idata, 20'h0A5A5);
        iaddr = 12'h042; step();
        chk("img_rd_42", idata, 20'h12345);

        // Bank steering
        cwr = 1'b1; csel = 3'd4; caddr_wr = 12'h3FF; cdata_wr = 20'h11111; step();
        csel = 3'd3; cdata_wr = 20'hFFFFF; step();
        cwr = 1'b0; dump_sel = 3'd3; dump_addr = 12'h3FF; step();
        chk("dump_l1k0_3ff", dump_data, 20'hFFFFF);
        dump_sel = 3'd4; step();
        chk("dump_l1k1_3ff", dump_data, 20'h11111);
        dump_sel = 3'd0; step();
        chk("dump_sel0", dump_data, 20'h00000);
        chk("steer_err", {19'd0, err}, 20'd0);

        // Read-before-write collision
        cwr = 1'b1; csel = 3'd1; caddr_wr = 12'h005; cdata_wr = 20'h00007; step();
        crd = 1'b1; caddr_rd = 12'h005; cdata_wr = 20'h00009; step();
        cwr = 1'b0; crd = 1'b0;
        chk("collide_old", cdata_rd, 20'h00007);
        crd = 1'b1; step();
        crd = 1'b0;
        chk("collide_new", cdata_rd, 20'h00009);
        step();
        chk("crd_hold", cdata_rd, 20'h00009);

        // Handshake
        start = 1'b1; step();
        start = 1'b0;
        chk("hs_ready", {19'd0, ready}, 20'd1);
        step(); step();
        busy = 1'b1; step();
        chk("hs_ready_drop", {19'd0, ready}, 20'd0);
        step();
        busy = 1'b0; step();
        chk("hs_done", {19'd0, done}, 20'd1);
        step();
        chk("hs_done_1cyc", {19'd0, done}, 20'd0);
        chk("hs_err", {19'd0, err}, 20'd0);

        // img_we during RUN is dropped and flags an error
        start = 1'b1; step();
        start = 1'b0; busy = 1'b1; step();
        img_we = 1'b1; img_addr = 12'h041; img_wdata = 20'h00001; step();
        img_we = 1'b0; busy = 1'b0; step(); step();
        iaddr = 12'h041; step();
        chk("img_run_err", {19'd0, err}, 20'd1);
        chk("img_run_kept", idata, 20'h0A5A5);

        // Invalid csel write
        do_reset();
        cwr = 1'b1; csel = 3'd6; caddr_wr = 12'h3FF; cdata_wr = 20'h22222; step();
        cwr = 1'b0;
        chk("csel6_err", {19'd0, err}, 20'd1);
        dump_sel = 3'd3; dump_addr = 12'h3FF; step();
        chk("csel6_l1k0", dump_data, 20'hFFFFF);
        dump_sel = 3'd4; step();
        chk("csel6_l1k1", dump_data, 20'h11111);

        // Out-of-range L1 address
        do_reset();
        cwr = 1'b1; csel = 3'd3; caddr_wr = 12'h000; cdata_wr = 20'h00ABC; step();
        chk("l1_w0_noerr", {19'd0, err}, 20'd0);
        caddr_wr = 12'h400; cdata_wr = 20'h55555; step();
        cwr = 1'b0;
        chk("l1_range_err", {19'd0, err}, 20'd1);
        dump_sel = 3'd3; dump_addr = 12'h000; step();
        chk("l1_w0_kept", dump_data, 20'h00ABC);

        // Dropped read leaves cdata_rd unchanged
        do_reset();
        crd = 1'b1; csel = 3'd1; caddr_rd = 12'h005; step();
        chk("rd_l0k0_5", cdata_rd, 20'h00009);
        csel = 3'd7; step();
        crd = 1'b0;
        chk("rd_bad_hold", cdata_rd, 20'h00009);
        chk("rd_bad_err", {19'd0, err}, 20'd1);

        // Timeout in ARM
        do_reset();
        saw_done = 1'b0;
        start = 1'b1; step();
        start = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            saw_done = saw_done | done;
        end
        chk("to_err_before", {19'd0, err}, 20'd0);
        chk("to_ready_before", {19'd0, ready}, 20'd1);
        step();
        saw_done = saw_done | done;
        chk("to_err", {19'd0, err}, 20'd1);
        chk("to_ready", {19'd0, ready}, 20'd0);
        step();
        saw_done = saw_done | done;
        chk("to_no_done", {19'd0, saw_done}, 20'd0);
        start = 1'b1; step();
        start = 1'b0;
        chk("to_back_idle", {19'd0, ready}, 20'd1);

        // Reset during RUN
        do_reset();
        start = 1'b1; step();
        start = 1'b0; busy = 1'b1; step();
        chk("mr_in_run", {19'd0, ready}, 20'd0);
        reset = 1'b1; step();
        reset = 1'b0; busy = 1'b0;
        chk("mr_ready", {19'd0, ready}, 20'd0);
        chk("mr_err", {19'd0, err}, 20'd0);
        chk("mr_done", {19'd0, done}, 20'd0);
        dump_sel = 3'd1; dump_addr = 12'h005; step();
        chk("mr_bank_kept", dump_data, 20'h00009);
        start = 1'b1; step();
        start = 1'b0;
        chk("mr_idle_start", {19'd0, ready}, 20'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
